// File: rtl/seq_detect_pkg.sv
// Shared types and reset-default constants for the serial pattern detector.
package seq_detect_pkg;

  typedef enum logic {ST_FILL, ST_ARMED} state_t;

  // Width needed to hold a length value in the range 0..max_len.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Reset configuration: the classic "001100" marker, overlapping.
  localparam int         DEF_MAX_LEN = 8;
  localparam logic [7:0] DEF_PATTERN = 8'b0000_1100;
  localparam int         DEF_LEN     = 6;
  localparam logic       DEF_OVERLAP = 1'b1;

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter; clear takes priority over increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  // count up to all-ones and hold there; clr wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (inc && cnt != '1)   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/seq_detect_param.sv
// Programmable serial bit-pattern detector with Mealy match output,
// overlap control, input qualification and a saturating match counter.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int                 MAX_LEN         = DEF_MAX_LEN,
  parameter int                 CNT_W           = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(DEF_PATTERN),
  parameter int                 DEFAULT_LEN     = DEF_LEN,
  parameter logic               DEFAULT_OVERLAP = DEF_OVERLAP,
  localparam int                LEN_W           = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               match,
  output logic               match_q,
  output logic               armed,
  output logic [CNT_W-1:0]   match_cnt
);

  logic [MAX_LEN-1:0] pattern, hist, hist_nxt, win, mask;
  logic [LEN_W-1:0]   len, len_ld, fill, fill_nxt;
  logic               overlap, accept, match_c;
  state_t             state, state_nxt;

  // clamp the programmed length into 1..MAX_LEN
  always_comb begin
    len_ld = cfg_len;
    if (cfg_len == '0)                     len_ld = LEN_W'(1);
    else if (cfg_len > LEN_W'(MAX_LEN))    len_ld = LEN_W'(MAX_LEN);
  end

  // window = newest len bits including the bit on the wire; compare under mask
  always_comb begin
    accept = en && in_valid && !cfg_we;
    win    = {hist[MAX_LEN-2:0], in_bit};
    mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (LEN_W'(i) < len);
    match_c = accept && (state == ST_ARMED) && (((win ^ pattern) & mask) == '0);
  end

  // history, fill level and FSM next-state; fill gates out stale history bits
  always_comb begin
    hist_nxt  = hist;
    fill_nxt  = fill;
    state_nxt = state;
    if (cfg_we) begin
      hist_nxt  = '0;
      fill_nxt  = '0;
      // a one-bit pattern needs no history, so it is armed straight away
      state_nxt = (len_ld == LEN_W'(1)) ? ST_ARMED : ST_FILL;
    end else if (accept) begin
      hist_nxt = win;
      if (match_c && !overlap) fill_nxt = '0;
      else if (fill < len)     fill_nxt = fill + 1'b1;
      state_nxt = (fill_nxt >= len - 1'b1) ? ST_ARMED : ST_FILL;
    end
  end

  // state registers and configuration load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist    <= '0;
      fill    <= '0;
      state   <= ST_FILL;
      match_q <= 1'b0;
      pattern <= DEFAULT_PATTERN;
      len     <= LEN_W'(DEFAULT_LEN);
      overlap <= DEFAULT_OVERLAP;
    end else begin
      hist    <= hist_nxt;
      fill    <= fill_nxt;
      state   <= state_nxt;
      match_q <= match_c;
      if (cfg_we) begin
        pattern <= cfg_pattern;
        len     <= len_ld;
        overlap <= cfg_overlap;
      end
    end
  end

  assign match = match_c;
  assign armed = (state == ST_ARMED);

  sat_counter #(.WIDTH(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (match_c),
    .clr (cnt_clr),
    .cnt (match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_seq_detect_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = 4;
  localparam int CMAX    = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               en, in_valid, in_bit, cfg_we, cfg_overlap, cnt_clr;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               match, match_q, armed;
  logic [CNT_W-1:0]   match_cnt;

  int errs   = 0;
  int checks = 0;

  // reference model: accepted bits since the last clear, plus config
  bit         mq[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ov;
  int         m_cnt;
  bit         m_mq;

  seq_detect_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .match(match),
    .match_q(match_q), .armed(armed), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void model_reset();
    mq.delete();
    m_pat = 8'b0000_1100; m_len = 6; m_ov = 1'b1; m_cnt = 0; m_mq = 1'b0;
  endfunction

  // last len bits received (oldest first) must read pattern[len-1] .. pattern[0]
  function automatic bit model_match(input bit b);
    int base;
    if (mq.size() < m_len - 1) return 1'b0;
    base = mq.size() - (m_len - 1);
    for (int k = 0; k < m_len - 1; k++)
      if (mq[base + k] != m_pat[m_len - 1 - k]) return 1'b0;
    return b == m_pat[0];
  endfunction

  // one clock of data; returns observed and modelled match for the cycle
  task automatic cycle(input bit e, input bit v, input bit b, input bit clr,
                       output logic om, output bit em);
    @(negedge clk);
    en = e; in_valid = v; in_bit = b; cnt_clr = clr; cfg_we = 1'b0;
    #1;
    om = match;
    em = (e && v) ? model_match(b) : 1'b0;
    @(posedge clk);
    if (e && v) begin
      mq.push_back(b);
      if (mq.size() > MAX_LEN) void'(mq.pop_front());
      if (em && !m_ov) mq.delete();
    end
    if (clr) m_cnt = 0;
    else if (em && m_cnt < CMAX) m_cnt++;
    m_mq = em;
    #1;
  endtask

  // configuration write with a bit offered in the same cycle
  task automatic do_cfg(input logic [7:0] p, input int l, input bit ov,
                        input bit vbit, output logic om);
    @(negedge clk);
    cfg_we = 1'b1; cfg_pattern = p; cfg_len = l[3:0]; cfg_overlap = ov;
    en = 1'b1; in_valid = vbit; in_bit = 1'b1; cnt_clr = 1'b0;
    #1;
    om = match;
    @(posedge clk);
    mq.delete();
    m_pat = p; m_ov = ov; m_mq = 1'b0;
    m_len = (l[3:0] == 0) ? 1 : (l[3:0] > MAX_LEN) ? MAX_LEN : int'(l[3:0]);
    #1;
    cfg_we = 1'b0;
  endtask

  // feed n bits, bits[n-1] first; per-bit match map in the same positions
  task automatic feed(input logic [15:0] bits, input int n, input bit clr,
                      output logic [15:0] obs);
    logic om; bit em;
    obs = '0;
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b1, bits[n-1-i], clr, om, em);
      obs[n-1-i] = om;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; in_valid = 1'b1; in_bit = 1'b0; cfg_we = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (match !== 1'b0) begin errs++; $display("FAIL reset_match got=%b want=0", match); end
    checks++; if (match_q !== 1'b0) begin errs++; $display("FAIL reset_match_q got=%b want=0", match_q); end
    checks++; if (armed !== 1'b0) begin errs++; $display("FAIL reset_armed got=%b want=0", armed); end
    checks++; if (match_cnt !== 2'd0) begin errs++; $display("FAIL reset_cnt got=%0d want=0", match_cnt); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_default();
    logic [15:0] obs;
    feed(16'b001100, 6, 1'b0, obs);
    checks++; if (obs[5:0] !== 6'b000001) begin errs++; $display("FAIL default_match got=%b want=000001", obs[5:0]); end
    checks++; if (match_q !== 1'b1) begin errs++; $display("FAIL default_match_q got=%b want=1", match_q); end
    checks++; if (match_cnt !== 2'd1) begin errs++; $display("FAIL default_cnt got=%0d want=1", match_cnt); end
    checks++; if (armed !== 1'b1) begin errs++; $display("FAIL default_armed got=%b want=1", armed); end
  endtask

  task automatic test_overlap();
    logic [15:0] obs; logic om; bit em;
    do_cfg(8'b101, 3, 1'b1, 1'b0, om);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, om, em);
    feed(16'b10101, 5, 1'b0, obs);
    checks++; if (obs[4:0] !== 5'b00101) begin errs++; $display("FAIL overlap_match got=%b want=00101", obs[4:0]); end
    checks++; if (match_cnt !== 2'd2) begin errs++; $display("FAIL overlap_cnt got=%0d want=2", match_cnt); end
  endtask

  task automatic test_nonoverlap();
    logic [15:0] obs; logic om;
    do_cfg(8'b101, 3, 1'b0, 1'b0, om);
    feed(16'b10101, 5, 1'b0, obs);
    checks++; if (obs[4:0] !== 5'b00100) begin errs++; $display("FAIL nonov_a got=%b want=00100", obs[4:0]); end
    do_cfg(8'b101, 3, 1'b0, 1'b0, om);
    feed(16'b101101, 6, 1'b0, obs);
    checks++; if (obs[5:0] !== 6'b001001) begin errs++; $display("FAIL nonov_b got=%b want=001001", obs[5:0]); end
  endtask

  task automatic test_gaps();
    logic [15:0] obs; logic om; bit em;
    do_cfg(8'b0000_1100, 6, 1'b1, 1'b0, om);
    feed(16'b001, 3, 1'b0, obs);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, om, em);
    checks++; if (om !== 1'b0) begin errs++; $display("FAIL gap_en_low got=%b want=0", om); end
    cycle(1'b1, 1'b0, 1'b1, 1'b0, om, em);
    checks++; if (om !== 1'b0) begin errs++; $display("FAIL gap_valid_low got=%b want=0", om); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, om, em);
    checks++; if (armed !== 1'b0) begin errs++; $display("FAIL gap_armed got=%b want=0", armed); end
    feed(16'b100, 3, 1'b0, obs);
    checks++; if (obs[2:0] !== 3'b001) begin errs++; $display("FAIL gap_match got=%b want=001", obs[2:0]); end
  endtask

  task automatic test_cfg_mid();
    logic [15:0] obs; logic om; bit em;
    logic [4:0] tail;
    tail = 5'b10011;
    do_cfg(8'b0000_1100, 6, 1'b1, 1'b0, om);
    feed(16'b001, 3, 1'b0, obs);
    do_cfg(8'b0000_1100, 6, 1'b1, 1'b1, om);
    checks++; if (om !== 1'b0) begin errs++; $display("FAIL cfg_same_cycle_match got=%b want=0", om); end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, tail[4-i], 1'b0, om, em);
      checks++; if (om !== 1'b0) begin errs++; $display("FAIL cfg_mid_match bit=%0d got=%b want=0", i, om); end
      checks++; if (armed !== (i == 4)) begin errs++; $display("FAIL cfg_mid_armed bit=%0d got=%b want=%b", i, armed, i == 4); end
    end
  endtask

  task automatic test_counter();
    logic [15:0] obs; logic om; bit em;
    do_cfg(8'b101, 3, 1'b1, 1'b0, om);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, om, em);
    feed(16'b10101010101, 11, 1'b0, obs);
    checks++; if (obs[10:0] !== 11'b00101010101) begin errs++; $display("FAIL cnt_matches got=%b want=00101010101", obs[10:0]); end
    checks++; if (match_cnt !== 2'd3) begin errs++; $display("FAIL cnt_saturate got=%0d want=3", match_cnt); end
    cycle(1'b1, 1'b1, 1'b0, 1'b0, om, em);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, om, em);
    checks++; if (om !== 1'b1) begin errs++; $display("FAIL cnt_clr_match got=%b want=1", om); end
    checks++; if (match_cnt !== 2'd0) begin errs++; $display("FAIL cnt_clr_priority got=%0d want=0", match_cnt); end
  endtask

  task automatic test_async_reset();
    logic [15:0] obs; logic om;
    do_cfg(8'b101, 3, 1'b1, 1'b0, om);
    feed(16'b101, 3, 1'b0, obs);
    feed(16'b001, 3, 1'b0, obs);
    @(posedge clk);
    #2;
    rst = 1'b0; en = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    #1;
    checks++; if (match !== 1'b0) begin errs++; $display("FAIL arst_match got=%b want=0", match); end
    checks++; if (match_q !== 1'b0) begin errs++; $display("FAIL arst_match_q got=%b want=0", match_q); end
    checks++; if (match_cnt !== 2'd0) begin errs++; $display("FAIL arst_cnt got=%0d want=0", match_cnt); end
    checks++; if (armed !== 1'b0) begin errs++; $display("FAIL arst_armed got=%b want=0", armed); end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    feed(16'b100, 3, 1'b0, obs);
    checks++; if (obs[2:0] !== 3'b000) begin errs++; $display("FAIL arst_partial got=%b want=000", obs[2:0]); end
    feed(16'b001100, 6, 1'b0, obs);
    checks++; if (obs[5:0] !== 6'b000001) begin errs++; $display("FAIL arst_full got=%b want=000001", obs[5:0]); end
  endtask

  task automatic test_random();
    logic om; bit em;
    int l;
    for (int k = 0; k < 8; k++) begin
      l = (k == 0) ? 0 : (k == 1) ? 12 : (k == 2) ? 8 : int'($urandom_range(1, 4));
      do_cfg(8'($urandom), l, 1'($urandom), 1'($urandom), om);
      checks++; if (om !== 1'b0) begin errs++; $display("FAIL rnd_cfg_match k=%0d got=%b want=0", k, om); end
      for (int c = 0; c < 150; c++) begin
        cycle(($urandom % 8) != 0, ($urandom % 8) != 0, 1'($urandom),
              ($urandom % 32) == 0, om, em);
        checks++; if (om !== em) begin errs++; $display("FAIL rnd_match k=%0d c=%0d got=%b want=%b", k, c, om, em); end
        checks++; if (match_q !== m_mq) begin errs++; $display("FAIL rnd_match_q k=%0d c=%0d got=%b want=%b", k, c, match_q, m_mq); end
        checks++; if (armed !== (mq.size() >= m_len - 1)) begin errs++; $display("FAIL rnd_armed k=%0d c=%0d got=%b want=%b", k, c, armed, mq.size() >= m_len - 1); end
        checks++; if (match_cnt !== 2'(m_cnt)) begin errs++; $display("FAIL rnd_cnt k=%0d c=%0d got=%0d want=%0d", k, c, match_cnt, m_cnt); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_overlap();
    test_nonoverlap();
    test_gaps();
    test_cfg_mid();
    test_counter();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
